// File: rtl/switch_allocator.sv
// switch_allocator: credit-aware round-robin switch allocator for the 5-port
// mesh router (N,S,E,W,L). grant_o/sel_o/valid_o are combinational so a granted
// flit pops in the same cycle; credits, round-robin pointers, locks and the
// sticky error flag are registered.
// Optional feature macro: ALLOC_PKT_LOCK_EN enables per-output wormhole packet
// locking. Without it, tail_i is ignored and every flit is arbitrated alone.
module switch_allocator #(
   parameter int NPORT        = 5,
   parameter int CREDIT_DEPTH = 4,
   parameter int CW           = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NPORT-1:0]      req_i,
   input  logic [3*NPORT-1:0]    dest_i,
   input  logic [NPORT-1:0]      tail_i,
   input  logic [NPORT-1:0]      credit_i,
   output logic [NPORT-1:0]      grant_o,
   output logic [3*NPORT-1:0]    sel_o,
   output logic [NPORT-1:0]      valid_o,
   output logic [CW*NPORT-1:0]   credit_o,
   output logic                  err_o
);

`ifdef ALLOC_PKT_LOCK_EN
   typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_t;
`else
   logic unused_tail;
   assign unused_tail = ^tail_i;
`endif

   logic [NPORT-1:0][NPORT-1:0] grant_mat;
   logic [NPORT-1:0]            sat_err;
   logic                        illegal_req;
   logic                        err_reg;
   logic                        err_next;

   // Any live request naming a non-existent port is an error and is never granted.
   always_comb begin
      illegal_req = 1'b0;
      for (int k = 0; k < NPORT; k++)
         if (req_i[k] && (dest_i[3*k +: 3] >= 3'(NPORT)))
            illegal_req = 1'b1;
   end

   generate
      for (genvar gi = 0; gi < NPORT; gi++) begin : g_out
         logic [CW-1:0]    credit_reg;
         logic [CW-1:0]    credit_next;
         logic [2:0]       rr_ptr_reg;
         logic [2:0]       rr_ptr_next;
         logic             lock_active;
         logic [2:0]       lock_owner;
         logic [NPORT-1:0] elig;
         logic [2:0]       cand;
         logic [2:0]       winner;
         logic             hit;
         logic             sat;

         // Inputs eligible for this output: matching request, credit left, lock owner only.
         always_comb begin
            elig = '0;
            for (int k = 0; k < NPORT; k++)
               elig[k] = req_i[k] && (dest_i[3*k +: 3] == 3'(gi)) && (credit_reg != '0)
                         && (!lock_active || (lock_owner == 3'(k)));
         end

         // Round-robin search from the pointer upward, wrapping past the last port.
         always_comb begin
            hit    = 1'b0;
            winner = '0;
            cand   = '0;
            for (int n = 0; n < NPORT; n++) begin
               cand = 3'((int'(rr_ptr_reg) + n) % NPORT);
               if (!hit && elig[cand]) begin
                  hit    = 1'b1;
                  winner = cand;
               end
            end
         end

         // Credit and pointer update; a credit return at full depth saturates and flags.
         always_comb begin
            credit_next = credit_reg;
            rr_ptr_next = rr_ptr_reg;
            sat         = 1'b0;
            if (hit && !credit_i[gi])
               credit_next = credit_reg - CW'(1);
            else if (!hit && credit_i[gi]) begin
               if (credit_reg == CW'(CREDIT_DEPTH))
                  sat = 1'b1;
               else
                  credit_next = credit_reg + CW'(1);
            end
            if (hit && !lock_active)
               rr_ptr_next = (winner == 3'(NPORT-1)) ? 3'd0 : winner + 3'd1;
         end

         // Per-output credit counter and round-robin pointer.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               credit_reg <= CW'(CREDIT_DEPTH);
               rr_ptr_reg <= '0;
            end else begin
               credit_reg <= credit_next;
               rr_ptr_reg <= rr_ptr_next;
            end
         end

`ifdef ALLOC_PKT_LOCK_EN
         lock_state_t state_reg;
         lock_state_t state_next;
         logic [2:0]  owner_reg;
         logic [2:0]  owner_next;

         // Lock on a non-tail grant, release on the owner's tail grant.
         always_comb begin
            state_next = state_reg;
            owner_next = owner_reg;
            case (state_reg)
               LOCK_IDLE: if (hit && !tail_i[winner]) begin
                  state_next = LOCK_HELD;
                  owner_next = winner;
               end
               LOCK_HELD: if (hit && tail_i[owner_reg])
                  state_next = LOCK_IDLE;
               default: state_next = LOCK_IDLE;
            endcase
         end

         // Lock state register.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_reg <= LOCK_IDLE;
               owner_reg <= '0;
            end else begin
               state_reg <= state_next;
               owner_reg <= owner_next;
            end
         end

         assign lock_active = (state_reg == LOCK_HELD);
         assign lock_owner  = owner_reg;
`else
         assign lock_active = 1'b0;
         assign lock_owner  = '0;
`endif

         assign grant_mat[gi]           = (rst && hit) ? (NPORT'(1) << winner) : '0;
         assign valid_o[gi]             = rst & hit;
         assign sel_o[3*gi +: 3]        = (rst && hit) ? winner : 3'd0;
         assign credit_o[CW*gi +: CW]   = credit_reg;
         assign sat_err[gi]             = sat;
      end
   endgenerate

   // Each input names one output, so OR-ing the per-output grant rows is safe.
   always_comb begin
      grant_o = '0;
      for (int j = 0; j < NPORT; j++)
         grant_o = grant_o | grant_mat[j];
   end

   assign err_next = err_reg | illegal_req | (|sat_err);

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err_reg <= 1'b0;
      else
         err_reg <= err_next;
   end

   assign err_o = err_reg;

endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed-vector bench for switch_allocator.
// Define ALLOC_PKT_LOCK_EN to also exercise packet locking.
module tb_switch_allocator;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  req_i, tail_i, credit_i, grant_o, valid_o;
   logic [14:0] dest_i, sel_o, credit_o;
   logic        err_o;
   int          n_vec = 0;
   int          n_bad = 0;

   switch_allocator dut (
      .clk(clk), .rst(rst), .req_i(req_i), .dest_i(dest_i), .tail_i(tail_i),
      .credit_i(credit_i), .grant_o(grant_o), .sel_o(sel_o), .valid_o(valid_o),
      .credit_o(credit_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] pack_dest(input logic [2:0] d0, d1, d2, d3, d4);
      return {d4, d3, d2, d1, d0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] r, input logic [14:0] d, input logic [4:0] t,
                        input logic [4:0] c);
      req_i = r; dest_i = d; tail_i = t; credit_i = c;
      #1;
      $display("t=%0t req=%b dest=%o tail=%b cred_in=%b -> grant=%b valid=%b sel=%o credit=%o err=%b",
               $time, req_i, dest_i, tail_i, credit_i, grant_o, valid_o, sel_o, credit_o, err_o);
   endtask

   task automatic test_reset();
      drive(5'b00001, pack_dest(2, 0, 0, 0, 0), 5'b11111, 5'b00000);
      tick(); tick();
      n_vec++; if (grant_o !== 5'b0) begin n_bad++; $display("FAIL reset_grant got=%b exp=%b", grant_o, 5'b0); end
      n_vec++; if (valid_o !== 5'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=%b", valid_o, 5'b0); end
      n_vec++; if (sel_o !== 15'b0) begin n_bad++; $display("FAIL reset_sel got=%o exp=%o", sel_o, 15'b0); end
      n_vec++; if (credit_o !== 15'o44444) begin n_bad++; $display("FAIL reset_credit got=%o exp=%o", credit_o, 15'o44444); end
      n_vec++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=%b", err_o, 1'b0); end
      rst = 1'b1;
   endtask

   task automatic test_basic();
      drive(5'b00001, pack_dest(2, 0, 0, 0, 0), 5'b11111, 5'b00000);
      n_vec++; if (grant_o !== 5'b00001) begin n_bad++; $display("FAIL basic_grant got=%b exp=%b", grant_o, 5'b00001); end
      n_vec++; if (valid_o !== 5'b00100) begin n_bad++; $display("FAIL basic_valid got=%b exp=%b", valid_o, 5'b00100); end
      n_vec++; if (sel_o !== 15'o00000) begin n_bad++; $display("FAIL basic_sel got=%o exp=%o", sel_o, 15'o00000); end
      tick();
      n_vec++; if (credit_o !== 15'o44344) begin n_bad++; $display("FAIL basic_credit got=%o exp=%o", credit_o, 15'o44344); end
      drive(5'b00000, 15'b0, 5'b00000, 5'b00100);
      tick();
      n_vec++; if (credit_o !== 15'o44444) begin n_bad++; $display("FAIL basic_restore got=%o exp=%o", credit_o, 15'o44444); end
   endtask

   task automatic test_round_robin();
      int exp_k [6] = '{0, 1, 3, 0, 1, 3};
      logic [4:0] e;
      for (int i = 0; i < 6; i++) begin
         drive(5'b01011, pack_dest(4, 4, 0, 4, 0), 5'b11111, 5'b10000);
         e = 5'b00001 << exp_k[i];
         n_vec++; if (grant_o !== e) begin n_bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, grant_o, e); end
         n_vec++; if (sel_o[14:12] !== 3'(exp_k[i])) begin n_bad++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", i, sel_o[14:12], exp_k[i]); end
         n_vec++; if (valid_o !== 5'b10000) begin n_bad++; $display("FAIL rr_valid[%0d] got=%b exp=%b", i, valid_o, 5'b10000); end
         tick();
      end
      drive(5'b00000, 15'b0, 5'b00000, 5'b00000);
      n_vec++; if (credit_o[14:12] !== 3'd4) begin n_bad++; $display("FAIL rr_credit got=%0d exp=%0d", credit_o[14:12], 4); end
   endtask

   task automatic test_credit_exhaust();
      for (int i = 0; i < 4; i++) begin
         drive(5'b10000, pack_dest(0, 0, 0, 0, 3), 5'b11111, 5'b00000);
         n_vec++; if (grant_o !== 5'b10000) begin n_bad++; $display("FAIL cred_grant[%0d] got=%b exp=%b", i, grant_o, 5'b10000); end
         tick();
      end
      n_vec++; if (credit_o[11:9] !== 3'd0) begin n_bad++; $display("FAIL cred_zero got=%0d exp=%0d", credit_o[11:9], 0); end
      drive(5'b10000, pack_dest(0, 0, 0, 0, 3), 5'b11111, 5'b00000);
      n_vec++; if (valid_o !== 5'b00000) begin n_bad++; $display("FAIL cred_block_valid got=%b exp=%b", valid_o, 5'b00000); end
      n_vec++; if (grant_o !== 5'b00000) begin n_bad++; $display("FAIL cred_block_grant got=%b exp=%b", grant_o, 5'b00000); end
      drive(5'b10000, pack_dest(0, 0, 0, 0, 3), 5'b11111, 5'b01000);
      n_vec++; if (valid_o !== 5'b00000) begin n_bad++; $display("FAIL cred_return_valid got=%b exp=%b", valid_o, 5'b00000); end
      tick();
      n_vec++; if (credit_o[11:9] !== 3'd1) begin n_bad++; $display("FAIL cred_one got=%0d exp=%0d", credit_o[11:9], 1); end
      drive(5'b10000, pack_dest(0, 0, 0, 0, 3), 5'b11111, 5'b00000);
      n_vec++; if (grant_o !== 5'b10000) begin n_bad++; $display("FAIL cred_extra_grant got=%b exp=%b", grant_o, 5'b10000); end
      tick();
      drive(5'b10000, pack_dest(0, 0, 0, 0, 3), 5'b11111, 5'b00000);
      n_vec++; if (grant_o !== 5'b00000) begin n_bad++; $display("FAIL cred_only_one got=%b exp=%b", grant_o, 5'b00000); end
      n_vec++; if (credit_o[11:9] !== 3'd0) begin n_bad++; $display("FAIL cred_zero2 got=%0d exp=%0d", credit_o[11:9], 0); end
      drive(5'b00000, 15'b0, 5'b00000, 5'b01000);
      repeat (4) tick();
      drive(5'b00000, 15'b0, 5'b00000, 5'b00000);
      n_vec++; if (credit_o !== 15'o44444) begin n_bad++; $display("FAIL cred_restore got=%o exp=%o", credit_o, 15'o44444); end
   endtask

`ifdef ALLOC_PKT_LOCK_EN
   task automatic test_pkt_lock();
      logic [4:0] r_tab [4] = '{5'b00110, 5'b00110, 5'b00110, 5'b00100};
      logic [4:0] t_tab [4] = '{5'b00000, 5'b00000, 5'b00010, 5'b00100};
      logic [4:0] g_tab [4] = '{5'b00010, 5'b00010, 5'b00010, 5'b00100};
      for (int i = 0; i < 4; i++) begin
         drive(r_tab[i], pack_dest(0, 0, 0, 0, 0), t_tab[i], 5'b00000);
         n_vec++; if (grant_o !== g_tab[i]) begin n_bad++; $display("FAIL lock_grant[%0d] got=%b exp=%b", i, grant_o, g_tab[i]); end
         tick();
      end
      drive(5'b00000, 15'b0, 5'b00000, 5'b00001);
      repeat (4) tick();
      drive(5'b00000, 15'b0, 5'b00000, 5'b00000);
      n_vec++; if (credit_o !== 15'o44444) begin n_bad++; $display("FAIL lock_restore got=%o exp=%o", credit_o, 15'o44444); end
   endtask
`endif

   task automatic test_illegal_dest();
      drive(5'b00100, pack_dest(0, 0, 6, 0, 0), 5'b00000, 5'b00000);
      n_vec++; if (grant_o !== 5'b00000) begin n_bad++; $display("FAIL illegal_grant got=%b exp=%b", grant_o, 5'b00000); end
      n_vec++; if (valid_o !== 5'b00000) begin n_bad++; $display("FAIL illegal_valid got=%b exp=%b", valid_o, 5'b00000); end
      n_vec++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL illegal_err_pre got=%b exp=%b", err_o, 1'b0); end
      tick();
      n_vec++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL illegal_err got=%b exp=%b", err_o, 1'b1); end
      drive(5'b00000, 15'b0, 5'b00000, 5'b00000);
      repeat (3) tick();
      n_vec++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL illegal_err_sticky got=%b exp=%b", err_o, 1'b1); end
      n_vec++; if (credit_o !== 15'o44444) begin n_bad++; $display("FAIL illegal_credit got=%o exp=%o", credit_o, 15'o44444); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(5'b00010, pack_dest(0, 0, 0, 0, 0), 5'b00000, 5'b00000);
         n_vec++; if (grant_o !== 5'b00010) begin n_bad++; $display("FAIL mid_grant[%0d] got=%b exp=%b", i, grant_o, 5'b00010); end
         tick();
      end
      n_vec++; if (credit_o[2:0] !== 3'd1) begin n_bad++; $display("FAIL mid_credit1 got=%0d exp=%0d", credit_o[2:0], 1); end
      rst = 1'b0;
      #1;
      n_vec++; if (grant_o !== 5'b0) begin n_bad++; $display("FAIL mid_rst_grant got=%b exp=%b", grant_o, 5'b0); end
      n_vec++; if (valid_o !== 5'b0) begin n_bad++; $display("FAIL mid_rst_valid got=%b exp=%b", valid_o, 5'b0); end
      n_vec++; if (credit_o !== 15'o44444) begin n_bad++; $display("FAIL mid_rst_credit got=%o exp=%o", credit_o, 15'o44444); end
      n_vec++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err got=%b exp=%b", err_o, 1'b0); end
      tick();
      n_vec++; if (grant_o !== 5'b0) begin n_bad++; $display("FAIL mid_rst_hold got=%b exp=%b", grant_o, 5'b0); end
      rst = 1'b1;
      drive(5'b01011, pack_dest(0, 0, 0, 0, 0), 5'b11111, 5'b00000);
      n_vec++; if (grant_o !== 5'b00001) begin n_bad++; $display("FAIL mid_restart_grant got=%b exp=%b", grant_o, 5'b00001); end
      n_vec++; if (valid_o !== 5'b00001) begin n_bad++; $display("FAIL mid_restart_valid got=%b exp=%b", valid_o, 5'b00001); end
      tick();
      drive(5'b00000, 15'b0, 5'b00000, 5'b00000);
      n_vec++; if (credit_o[2:0] !== 3'd3) begin n_bad++; $display("FAIL mid_restart_credit got=%0d exp=%0d", credit_o[2:0], 3); end
   endtask

   task automatic test_saturate();
      drive(5'b00000, 15'b0, 5'b00000, 5'b00010);
      n_vec++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL sat_err_pre got=%b exp=%b", err_o, 1'b0); end
      tick();
      drive(5'b00000, 15'b0, 5'b00000, 5'b00000);
      n_vec++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL sat_err got=%b exp=%b", err_o, 1'b1); end
      n_vec++; if (credit_o[5:3] !== 3'd4) begin n_bad++; $display("FAIL sat_count got=%0d exp=%0d", credit_o[5:3], 4); end
      n_vec++; if (credit_o[2:0] !== 3'd3) begin n_bad++; $display("FAIL sat_other got=%0d exp=%0d", credit_o[2:0], 3); end
   endtask

   initial begin
      rst = 1'b0;
      req_i = '0; dest_i = '0; tail_i = '0; credit_i = '0;
      test_reset();
      test_basic();
      test_round_robin();
      test_credit_exhaust();
`ifdef ALLOC_PKT_LOCK_EN
      test_pkt_lock();
`endif
      test_illegal_dest();
      test_reset_mid();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
